mem_req_arbiter: RTL and testbench

- Shares the single downstream memory-controller request port between three requesters: instruction-fetch refill (IF), load port (LD) and store port (ST).
- Fixed priority ST > LD > IF, with a starvation guard for IF.
- Handles rollback: cancels pending and in-flight speculative traffic; committed stores always complete.
- Sits between the fetch unit / load-store buffer and the byte-serial memory controller.

---
 rtl/mem_req_arbiter_if.sv | 59 +++++
 rtl/mem_req_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Requester and memory-controller signal bundle for mem_req_arbiter.
interface mem_req_arbiter_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 3;

  logic              rdy;
  logic              rollback;

  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              ld_req;
  logic [DATA_W-1:0] ld_addr;
  logic [LEN_W-1:0]  ld_len;
  logic              ld_done;
  logic [DATA_W-1:0] ld_rdata;

  logic              st_req;
  logic [DATA_W-1:0] st_addr;
  logic [LEN_W-1:0]  st_len;
  logic [DATA_W-1:0] st_wdata;
  logic              st_done;

  logic              mc_en;
  logic              mc_wr;
  logic [DATA_W-1:0] mc_addr;
  logic [LEN_W-1:0]  mc_len;
  logic [DATA_W-1:0] mc_wdata;
  logic              mc_done;
  logic [DATA_W-1:0] mc_rdata;

  // Arbiter side.
  modport slave (
    input  rdy, rollback,
    input  if_req, if_addr,
    output if_done, if_rdata,
    input  ld_req, ld_addr, ld_len,
    output ld_done, ld_rdata,
    input  st_req, st_addr, st_len, st_wdata,
    output st_done,
    output mc_en, mc_wr, mc_addr, mc_len, mc_wdata,
    input  mc_done, mc_rdata
  );

  // Requesters plus memory controller side.
  modport master (
    output rdy, rollback,
    output if_req, if_addr,
    input  if_done, if_rdata,
    output ld_req, ld_addr, ld_len,
    input  ld_done, ld_rdata,
    output st_req, st_addr, st_len, st_wdata,
    input  st_done,
    input  mc_en, mc_wr, mc_addr, mc_len, mc_wdata,
    output mc_done, mc_rdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Three-way arbiter (ST > LD > IF, with IF starvation guard) in front of the
// byte-serial memory controller; cancels speculative traffic on rollback.
module mem_req_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned IF_LEN       = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_req_arbiter_if.slave bus_io
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_GAP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD, OWN_ST} owner_t;

  state_t             state_q, state_d;
  owner_t             owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [DATA_W-1:0]  pend_rdata_q, pend_rdata_d;

  logic               mc_en_q, mc_en_d;
  logic               mc_wr_q, mc_wr_d;
  logic [DATA_W-1:0]  mc_addr_q, mc_addr_d;
  logic [LEN_W-1:0]   mc_len_q, mc_len_d;
  logic [DATA_W-1:0]  mc_wdata_q, mc_wdata_d;
  logic               if_done_q, if_done_d;
  logic               ld_done_q, ld_done_d;
  logic               st_done_q, st_done_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]  ld_rdata_q, ld_rdata_d;

  owner_t             gnt_c;
  logic               starved_c;
  logic               done_evt_c;
  logic [DATA_W-1:0]  done_data_c;

  // A completion seen while rdy was low is replayed from the pending latch.
  assign done_evt_c  = bus_io.mc_done | pend_q;
  assign done_data_c = pend_q ? pend_rdata_q : bus_io.mc_rdata;
  assign starved_c   = (cnt_q == CNT_W'(STARVE_LIMIT));

  // Grant selection for the IDLE state; rollback blocks speculative LD/IF.
  always_comb begin
    gnt_c = OWN_NONE;
    if (bus_io.if_req && starved_c && !bus_io.rollback) begin
      gnt_c = OWN_IF;
    end else if (bus_io.st_req) begin
      gnt_c = OWN_ST;
    end else if (bus_io.ld_req && !bus_io.rollback) begin
      gnt_c = OWN_LD;
    end else if (bus_io.if_req && !bus_io.rollback) begin
      gnt_c = OWN_IF;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_rdata_d = pend_rdata_q;
    mc_en_d      = mc_en_q;
    mc_wr_d      = mc_wr_q;
    mc_addr_d    = mc_addr_q;
    mc_len_d     = mc_len_q;
    mc_wdata_d   = mc_wdata_q;
    if_done_d    = if_done_q;
    ld_done_d    = ld_done_q;
    st_done_d    = st_done_q;
    if_rdata_d   = if_rdata_q;
    ld_rdata_d   = ld_rdata_q;

    if (!bus_io.rdy) begin
      if ((state_q == S_BUSY || state_q == S_DRAIN) && bus_io.mc_done && !pend_q) begin
        pend_d       = 1'b1;
        pend_rdata_d = bus_io.mc_rdata;
      end
    end else begin
      pend_d    = 1'b0;
      if_done_d = 1'b0;
      ld_done_d = 1'b0;
      st_done_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt_c != OWN_NONE) begin
            owner_d = gnt_c;
            state_d = S_BUSY;
            mc_en_d = 1'b1;
            if (gnt_c == OWN_IF || !bus_io.if_req) begin
              cnt_d = '0;
            end else if (!starved_c) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            unique case (gnt_c)
              OWN_ST: begin
                mc_wr_d    = 1'b1;
                mc_addr_d  = bus_io.st_addr;
                mc_len_d   = bus_io.st_len;
                mc_wdata_d = bus_io.st_wdata;
              end
              OWN_LD: begin
                mc_wr_d    = 1'b0;
                mc_addr_d  = bus_io.ld_addr;
                mc_len_d   = bus_io.ld_len;
                mc_wdata_d = '0;
              end
              default: begin
                mc_wr_d    = 1'b0;
                mc_addr_d  = bus_io.if_addr;
                mc_len_d   = LEN_W'(IF_LEN);
                mc_wdata_d = '0;
              end
            endcase
          end
        end
        S_BUSY: begin
          if (owner_q == OWN_LD && bus_io.rollback) begin
            mc_en_d = 1'b0;
            state_d = S_GAP;
          end else if (owner_q == OWN_IF && bus_io.rollback) begin
            // Fetch cannot be aborted downstream; its completion is swallowed.
            mc_en_d = 1'b0;
            state_d = done_evt_c ? S_GAP : S_DRAIN;
          end else if (done_evt_c) begin
            mc_en_d = 1'b0;
            state_d = S_GAP;
            unique case (owner_q)
              OWN_IF: begin
                if_done_d  = 1'b1;
                if_rdata_d = done_data_c;
              end
              OWN_LD: begin
                ld_done_d  = 1'b1;
                ld_rdata_d = done_data_c;
              end
              OWN_ST:  st_done_d = 1'b1;
              default: ;
            endcase
          end
        end
        S_DRAIN: begin
          if (done_evt_c) begin
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          owner_d = OWN_NONE;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_NONE;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      pend_rdata_q <= '0;
      mc_en_q      <= 1'b0;
      mc_wr_q      <= 1'b0;
      mc_addr_q    <= '0;
      mc_len_q     <= '0;
      mc_wdata_q   <= '0;
      if_done_q    <= 1'b0;
      ld_done_q    <= 1'b0;
      st_done_q    <= 1'b0;
      if_rdata_q   <= '0;
      ld_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_rdata_q <= pend_rdata_d;
      mc_en_q      <= mc_en_d;
      mc_wr_q      <= mc_wr_d;
      mc_addr_q    <= mc_addr_d;
      mc_len_q     <= mc_len_d;
      mc_wdata_q   <= mc_wdata_d;
      if_done_q    <= if_done_d;
      ld_done_q    <= ld_done_d;
      st_done_q    <= st_done_d;
      if_rdata_q   <= if_rdata_d;
      ld_rdata_q   <= ld_rdata_d;
    end
  end

  assign bus_io.mc_en    = mc_en_q;
  assign bus_io.mc_wr    = mc_wr_q;
  assign bus_io.mc_addr  = mc_addr_q;
  assign bus_io.mc_len   = mc_len_q;
  assign bus_io.mc_wdata = mc_wdata_q;
  assign bus_io.if_done  = if_done_q;
  assign bus_io.ld_done  = ld_done_q;
  assign bus_io.st_done  = st_done_q;
  assign bus_io.if_rdata = if_rdata_q;
  assign bus_io.ld_rdata = ld_rdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: vector table plus multi-cycle sequences.
module tb_mem_req_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned IF_LEN       = 4;
  localparam logic [1:0]  O_IF = 2'd1;
  localparam logic [1:0]  O_LD = 2'd2;
  localparam logic [1:0]  O_ST = 2'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_req_arbiter_if bus ();

  mem_req_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .IF_LEN       (IF_LEN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct {
    logic        st, ld, fi;
    logic [31:0] st_addr;
    logic [2:0]  st_len;
    logic [31:0] st_wdata;
    logic [31:0] ld_addr;
    logic [2:0]  ld_len;
    logic [31:0] if_addr;
    int          n;
    logic [1:0]  o0, o1, o2;
    logic [31:0] r0, r1, r2;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int n_ifd = 0, n_ldd = 0, n_std = 0;
  int exp_ifd = 0, exp_ldd = 0, exp_std = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_ld = '0;

  // Done-pulse counters (pre-edge sample of the registered outputs).
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.if_done) n_ifd++;
      if (bus.ld_done) n_ldd++;
      if (bus.st_done) n_std++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Waits for mc_en; the grant must appear exactly one cycle after the call.
  task automatic wait_en(input string nm);
    int lat;
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      lat++;
      if (bus.mc_en) break;
    end
    chk({nm, "_mc_en"}, 32'(bus.mc_en), 32'd1);
    chk({nm, "_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic chk_grant(input string nm, input logic wr, input logic [31:0] addr,
                           input logic [2:0] len, input logic [31:0] wd);
    chk({nm, "_wr"}, 32'(bus.mc_wr), 32'(wr));
    chk({nm, "_addr"}, bus.mc_addr, addr);
    chk({nm, "_len"}, 32'(bus.mc_len), 32'(len));
    chk({nm, "_wdata"}, bus.mc_wdata, wd);
  endtask

  // Pulses mc_done, checks the done pulse, rdata, GAP and pulse width.
  task automatic complete(input string nm, input logic [1:0] own, input logic [31:0] rd);
    bus.mc_done  = 1'b1;
    bus.mc_rdata = rd;
    tick();
    bus.mc_done  = 1'b0;
    bus.mc_rdata = '0;
    chk({nm, "_st_done"}, 32'(bus.st_done), 32'(own == O_ST));
    chk({nm, "_ld_done"}, 32'(bus.ld_done), 32'(own == O_LD));
    chk({nm, "_if_done"}, 32'(bus.if_done), 32'(own == O_IF));
    chk({nm, "_gap_mc_en"}, 32'(bus.mc_en), 32'd0);
    if (own == O_LD) begin
      last_ld = rd;
      exp_ldd++;
      bus.ld_req = 1'b0;
    end else if (own == O_IF) begin
      last_if = rd;
      exp_ifd++;
      bus.if_req = 1'b0;
    end else begin
      exp_std++;
      bus.st_req = 1'b0;
    end
    chk({nm, "_ld_rdata"}, bus.ld_rdata, last_ld);
    chk({nm, "_if_rdata"}, bus.if_rdata, last_if);
    tick();
    chk({nm, "_width"}, 32'({bus.st_done, bus.ld_done, bus.if_done}), 32'd0);
    chk({nm, "_idle_mc_en"}, 32'(bus.mc_en), 32'd0);
  endtask

  function automatic vec_t mk(logic st, logic ld, logic fi,
                              logic [31:0] sa, logic [2:0] sl, logic [31:0] sw,
                              logic [31:0] la, logic [2:0] ll, logic [31:0] ia,
                              int n, logic [1:0] o0, logic [1:0] o1, logic [1:0] o2,
                              logic [31:0] r0, logic [31:0] r1, logic [31:0] r2);
    vec_t v;
    v.st = st; v.ld = ld; v.fi = fi;
    v.st_addr = sa; v.st_len = sl; v.st_wdata = sw;
    v.ld_addr = la; v.ld_len = ll; v.if_addr = ia;
    v.n = n; v.o0 = o0; v.o1 = o1; v.o2 = o2;
    v.r0 = r0; v.r1 = r1; v.r2 = r2;
    return v;
  endfunction

  vec_t vecs[6];

  initial begin
    vec_t        v;
    logic [1:0]  own;
    logic [31:0] rd;
    logic        e_wr;
    logic [31:0] e_addr, e_wd;
    logic [2:0]  e_len;

    vecs[0] = mk(0, 1, 0, 32'h0,   3'd0, 32'h0,        32'h100, 3'd4, 32'h0,
                 1, O_LD, 2'd0, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    vecs[1] = mk(1, 0, 0, 32'h200, 3'd2, 32'h1234ABCD, 32'h0,   3'd0, 32'h0,
                 1, O_ST, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0);
    vecs[2] = mk(0, 0, 1, 32'h0,   3'd0, 32'h0,        32'h0,   3'd0, 32'h3000,
                 1, O_IF, 2'd0, 2'd0, 32'h13579BDF, 32'h0, 32'h0);
    vecs[3] = mk(1, 1, 1, 32'h400, 3'd4, 32'hCAFEF00D, 32'h104, 3'd1, 32'h3010,
                 3, O_ST, O_LD, O_IF, 32'h0, 32'hA1A1A1A1, 32'hB2B2B2B2);
    vecs[4] = mk(0, 1, 1, 32'h0,   3'd0, 32'h0,        32'h108, 3'd2, 32'h3020,
                 2, O_LD, O_IF, 2'd0, 32'h00C0FFEE, 32'hFEEDFACE, 32'h0);
    vecs[5] = mk(1, 1, 0, 32'h500, 3'd1, 32'h000000AA, 32'h10C, 3'd4, 32'h0,
                 2, O_ST, O_LD, 2'd0, 32'h0, 32'h87654321, 32'h0);

    rst = 1'b1;
    bus.rdy = 1'b1;  bus.rollback = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_len = '0;
    bus.st_req = 1'b0; bus.st_addr = '0; bus.st_len = '0; bus.st_wdata = '0;
    bus.mc_done = 1'b0; bus.mc_rdata = '0;
    repeat (3) tick();
    chk("rst_mc_en", 32'(bus.mc_en), 32'd0);
    chk("rst_mc_wr", 32'(bus.mc_wr), 32'd0);
    chk("rst_mc_addr", bus.mc_addr, 32'd0);
    chk("rst_mc_len", 32'(bus.mc_len), 32'd0);
    chk("rst_mc_wdata", bus.mc_wdata, 32'd0);
    chk("rst_dones", 32'({bus.st_done, bus.ld_done, bus.if_done}), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_ld_rdata", bus.ld_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven transactions.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      bus.st_addr = v.st_addr; bus.st_len = v.st_len; bus.st_wdata = v.st_wdata;
      bus.ld_addr = v.ld_addr; bus.ld_len = v.ld_len; bus.if_addr = v.if_addr;
      bus.st_req = v.st; bus.ld_req = v.ld; bus.if_req = v.fi;
      for (int k = 0; k < v.n; k++) begin
        own = (k == 0) ? v.o0 : (k == 1) ? v.o1 : v.o2;
        rd  = (k == 0) ? v.r0 : (k == 1) ? v.r1 : v.r2;
        if (own == O_ST) begin
          e_wr = 1'b1; e_addr = v.st_addr; e_len = v.st_len; e_wd = v.st_wdata;
        end else if (own == O_LD) begin
          e_wr = 1'b0; e_addr = v.ld_addr; e_len = v.ld_len; e_wd = '0;
        end else begin
          e_wr = 1'b0; e_addr = v.if_addr; e_len = 3'(IF_LEN); e_wd = '0;
        end
        wait_en($sformatf("v%0d_g%0d", i, k));
        chk_grant($sformatf("v%0d_g%0d", i, k), e_wr, e_addr, e_len, e_wd);
        complete($sformatf("v%0d_g%0d", i, k), own, rd);
      end
    end

    // Starvation: LD x4, then promoted IF, then LD again (counter cleared), then IF.
    bus.ld_addr = 32'h180; bus.ld_len = 3'd4; bus.if_addr = 32'h3100;
    bus.ld_req = 1'b1; bus.if_req = 1'b1;
    for (int g = 0; g < 7; g++) begin
      own = (g < 4 || g == 5) ? O_LD : O_IF;
      wait_en($sformatf("starve_g%0d", g));
      chk($sformatf("starve_g%0d_addr", g), bus.mc_addr, (own == O_LD) ? 32'h180 : 32'h3100);
      complete($sformatf("starve_g%0d", g), own, 32'h5A000000 + 32'(g));
      if (g < 4) bus.ld_req = 1'b1;
      if (g == 4) bus.if_req = 1'b1;
    end

    // Rollback on in-flight IF, with a store waiting behind it.
    bus.if_addr = 32'h3200; bus.if_req = 1'b1;
    tick();
    chk("rbif_mc_en", 32'(bus.mc_en), 32'd1);
    chk("rbif_addr", bus.mc_addr, 32'h3200);
    bus.st_addr = 32'h600; bus.st_len = 3'd4; bus.st_wdata = 32'h5555AAAA; bus.st_req = 1'b1;
    tick();
    bus.rollback = 1'b1; bus.if_req = 1'b0;
    tick();
    chk("rbif_drop", 32'(bus.mc_en), 32'd0);
    bus.rollback = 1'b0;
    tick();
    chk("rbif_drain1", 32'(bus.mc_en), 32'd0);
    tick();
    chk("rbif_drain2", 32'(bus.mc_en), 32'd0);
    bus.mc_done = 1'b1; bus.mc_rdata = 32'hBAD0BAD0;
    tick();
    bus.mc_done = 1'b0; bus.mc_rdata = '0;
    chk("rbif_no_done", 32'(bus.if_done), 32'd0);
    chk("rbif_gap", 32'(bus.mc_en), 32'd0);
    tick();
    chk("rbif_idle", 32'(bus.mc_en), 32'd0);
    wait_en("rbif_st");
    chk_grant("rbif_st", 1'b1, 32'h600, 3'd4, 32'h5555AAAA);
    complete("rbif_st", O_ST, 32'h0);

    // Rollback on in-flight LD: mc_en drops, no ld_done.
    bus.ld_addr = 32'h700; bus.ld_len = 3'd2; bus.ld_req = 1'b1;
    tick();
    chk("rbld_mc_en", 32'(bus.mc_en), 32'd1);
    tick();
    bus.rollback = 1'b1; bus.ld_req = 1'b0;
    tick();
    chk("rbld_drop", 32'(bus.mc_en), 32'd0);
    bus.rollback = 1'b0;
    tick();
    chk("rbld_no_done", 32'(bus.ld_done), 32'd0);
    tick();
    chk("rbld_no_done2", 32'(bus.ld_done), 32'd0);

    // Rollback on in-flight ST: ignored, store completes.
    bus.st_addr = 32'h800; bus.st_len = 3'd4; bus.st_wdata = 32'h0BADCAFE; bus.st_req = 1'b1;
    wait_en("rbst");
    chk_grant("rbst", 1'b1, 32'h800, 3'd4, 32'h0BADCAFE);
    tick();
    bus.rollback = 1'b1;
    tick();
    bus.rollback = 1'b0;
    chk("rbst_hold", 32'(bus.mc_en), 32'd1);
    complete("rbst", O_ST, 32'h0);

    // rdy low across mc_done: ld_done deferred until rdy returns.
    bus.ld_addr = 32'hB00; bus.ld_len = 3'd2; bus.ld_req = 1'b1;
    wait_en("rdy");
    bus.rdy = 1'b0;
    tick();
    chk("rdy_no_done0", 32'(bus.ld_done), 32'd0);
    bus.mc_done = 1'b1; bus.mc_rdata = 32'h600D600D;
    tick();
    bus.mc_done = 1'b0; bus.mc_rdata = 32'hFFFFFFFF;
    chk("rdy_no_done1", 32'(bus.ld_done), 32'd0);
    chk("rdy_hold_en", 32'(bus.mc_en), 32'd1);
    tick();
    chk("rdy_no_done2", 32'(bus.ld_done), 32'd0);
    chk("rdy_hold_en2", 32'(bus.mc_en), 32'd1);
    bus.rdy = 1'b1;
    tick();
    bus.mc_rdata = '0;
    chk("rdy_done", 32'(bus.ld_done), 32'd1);
    chk("rdy_rdata", bus.ld_rdata, 32'h600D600D);
    chk("rdy_mc_en", 32'(bus.mc_en), 32'd0);
    bus.ld_req = 1'b0;
    exp_ldd++;
    last_ld = 32'h600D600D;
    tick();
    chk("rdy_width", 32'(bus.ld_done), 32'd0);
    tick();

    // Rollback in IDLE blocks LD but a store still gets granted.
    bus.ld_addr = 32'h900; bus.ld_len = 3'd4; bus.ld_req = 1'b1; bus.rollback = 1'b1;
    tick();
    chk("idle_rb_ld_blocked", 32'(bus.mc_en), 32'd0);
    bus.rollback = 1'b0;
    tick();
    chk("idle_rb_ld_later", 32'(bus.mc_en), 32'd1);
    chk("idle_rb_ld_addr", bus.mc_addr, 32'h900);
    complete("idle_rb_ld", O_LD, 32'h11223344);
    bus.st_addr = 32'hA00; bus.st_len = 3'd1; bus.st_wdata = 32'h77; bus.st_req = 1'b1;
    bus.rollback = 1'b1;
    tick();
    bus.rollback = 1'b0;
    chk("idle_rb_st_en", 32'(bus.mc_en), 32'd1);
    chk_grant("idle_rb_st", 1'b1, 32'hA00, 3'd1, 32'h77);
    complete("idle_rb_st", O_ST, 32'h0);

    // Stray mc_done in IDLE is ignored.
    bus.mc_done = 1'b1; bus.mc_rdata = 32'h99999999;
    tick();
    bus.mc_done = 1'b0; bus.mc_rdata = '0;
    tick();
    chk("stray_dones", 32'({bus.st_done, bus.ld_done, bus.if_done}), 32'd0);
    chk("stray_ld_rdata", bus.ld_rdata, last_ld);
    tick();

    chk("cnt_if_done", 32'(n_ifd), 32'(exp_ifd));
    chk("cnt_ld_done", 32'(n_ldd), 32'(exp_ldd));
    chk("cnt_st_done", 32'(n_std), 32'(exp_std));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
